// File: rtl/desc_frame_ring.sv
// Frame bookkeeping between the descriptor stage and the matcher: per-view descriptor
// counting with RAM write addressing, and a ring of committed groups with release handshake.
module desc_frame_ring #(
  parameter int NUM_VIEWS  = 2,
  parameter int RING_DEPTH = 4,
  parameter int ADDR_W     = 10,
  parameter int VIEW_W     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          img_din_valid,
  input  logic                          feat_flag,
  input  logic                          feat_valid,
  output logic                          wr_en,
  output logic [VIEW_W-1:0]             wr_view,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic                          commit,
  output logic                          rd_valid,
  input  logic                          rd_release,
  output logic [NUM_VIEWS*ADDR_W-1:0]   rd_counts,
  output logic [NUM_VIEWS-1:0]          rd_ovf,
  output logic [NUM_VIEWS*ADDR_W-1:0]   rd_prev_counts,
  output logic                          rd_prev_valid,
  output logic [7:0]                    drop_cnt
);

  localparam int CW    = NUM_VIEWS * ADDR_W;
  localparam int PTR_W = (RING_DEPTH > 1) ? $clog2(RING_DEPTH) : 1;
  localparam int OCC_W = $clog2(RING_DEPTH + 1);
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t              state_q, state_d;
  logic                vin_q;
  logic                start, hit, last_view, counting;
  logic [VIEW_W-1:0]   view_q, view_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_upd;
  logic [NUM_VIEWS-1:0] ovf_q, ovf_d, ovf_upd;
  logic [ADDR_W-1:0]   sel_cnt;
  logic                sel_sat;

  logic [CW-1:0]        ring_cnt_q [RING_DEPTH];
  logic [NUM_VIEWS-1:0] ring_ovf_q [RING_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]     occ_q;
  logic [CW-1:0]        prev_cnt_q;
  logic                 prev_valid_q;
  logic [7:0]           drop_q;
  logic                 rel_fire, accept, drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RING_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign start     = img_din_valid & ~vin_q;
  assign hit       = feat_flag & feat_valid;
  assign counting  = (state_q == S_COUNT);
  assign last_view = (view_q == VIEW_W'(NUM_VIEWS - 1));
  assign sel_sat   = (sel_cnt == CNT_MAX);

  always_comb begin
    sel_cnt = '0;
    for (int unsigned v = 0; v < NUM_VIEWS; v++) begin
      if (view_q == VIEW_W'(v)) sel_cnt = cnt_q[v*ADDR_W +: ADDR_W];
    end
  end

  // Counts with this cycle's hit folded in; this is what a boundary commit captures.
  always_comb begin
    cnt_upd = cnt_q;
    ovf_upd = ovf_q;
    for (int unsigned v = 0; v < NUM_VIEWS; v++) begin
      if (view_q == VIEW_W'(v)) begin
        if (wr_en) cnt_upd[v*ADDR_W +: ADDR_W] = sel_cnt + ADDR_W'(1);
        if (hit && counting && sel_sat) ovf_upd[v] = 1'b1;
      end
    end
  end

  // Tracker: state register
  always_ff @(posedge clk) begin
    // Sampled through reset so a valid already high at release is not a start.
    vin_q <= img_din_valid;
    if (rst) begin
      state_q <= S_IDLE;
      view_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      view_q  <= view_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Tracker: next state
  always_comb begin
    state_d = state_q;
    view_d  = view_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COUNT;
          view_d  = '0;
          cnt_d   = '0;
          ovf_d   = '0;
        end
      end
      S_COUNT: begin
        cnt_d = cnt_upd;
        ovf_d = ovf_upd;
        if (start) begin
          if (last_view) begin
            view_d = '0;
            cnt_d  = '0;
            ovf_d  = '0;
          end else begin
            view_d = view_q + VIEW_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tracker: outputs
  always_comb begin
    wr_en   = hit & counting & ~sel_sat;
    wr_view = view_q;
    wr_addr = sel_cnt;
    commit  = counting & start & last_view;
  end

  // A same-cycle release frees the head slot, so a commit into a full ring still lands.
  assign rd_valid = (occ_q != '0);
  assign rel_fire = rd_release & rd_valid;
  assign accept   = commit & ((occ_q != OCC_W'(RING_DEPTH)) | rel_fire);
  assign drop     = commit & ~accept;

  assign rd_counts      = ring_cnt_q[rd_ptr_q];
  assign rd_ovf         = ring_ovf_q[rd_ptr_q];
  assign rd_prev_counts = prev_cnt_q;
  assign rd_prev_valid  = prev_valid_q;
  assign drop_cnt       = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RING_DEPTH; i++) begin
        ring_cnt_q[i] <= '0;
        ring_ovf_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      prev_cnt_q   <= '0;
      prev_valid_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      if (accept) begin
        ring_cnt_q[wr_ptr_q] <= cnt_upd;
        ring_ovf_q[wr_ptr_q] <= ovf_upd;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (rel_fire) begin
        prev_cnt_q   <= rd_counts;
        prev_valid_q <= 1'b1;
        rd_ptr_q     <= ptr_inc(rd_ptr_q);
      end
      if (accept && !rel_fire) begin
        occ_q <= occ_q + OCC_W'(1);
      end else if (rel_fire && !accept) begin
        occ_q <= occ_q - OCC_W'(1);
      end
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

endmodule

// File: doc/desc_frame_ring.md
Name: desc_frame_ring

Overview:
- Frame-bookkeeping controller between the detector/descriptor stage and the matcher.
- Generalises single-pair left/right counting to NUM_VIEWS views per group and a RING_DEPTH-deep count ring.
- Detects view boundaries from pixel-valid bursts, counts descriptors per view, and generates descriptor-RAM write enable/address.
- At each group boundary, commits per-view counts into the ring, where the matcher consumes them with a release handshake; overflow saturation and drop accounting included.

Parameters:
- NUM_VIEWS, 2, views per group (2 = left/right stereo); legal 1..8.
- RING_DEPTH, 4, committed groups held for the matcher; legal 2..8.
- ADDR_W, 10, descriptor count/address width; per-view count saturates at 2^ADDR_W-1.
- VIEW_W, 3, view index width; must satisfy 2^VIEW_W >= NUM_VIEWS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- img_din_valid  in  1  pixel-valid; each 0->1 edge starts a new view.
- feat_flag  in  1  current descriptor is a feature.
- feat_valid  in  1  descriptor output valid.
- wr_en  out  1  descriptor RAM write enable.
- wr_view  out  VIEW_W  view being written.
- wr_addr  out  ADDR_W  write address = current view count.
- commit  out  1  one-cycle pulse: group written into ring.
- rd_valid  out  1  ring non-empty.
- rd_release  in  1  matcher done with head group.
- rd_counts  out  NUM_VIEWS*ADDR_W  head group counts, view v at bits [v*ADDR_W +: ADDR_W].
- rd_ovf  out  NUM_VIEWS  head group per-view saturation flags.
- rd_prev_counts  out  NUM_VIEWS*ADDR_W  counts of the last released group (temporal matching).
- rd_prev_valid  out  1  rd_prev_counts meaningful.
- drop_cnt  out  8  groups dropped on ring full, saturating at 255.

Behaviour:
- All state is on clk; rst is synchronous and active-high and clears everything.
- Reset values: wr_en=0, wr_view=0, wr_addr=0, commit=0, rd_valid=0, rd_counts=0, rd_ovf=0, rd_prev_counts=0, rd_prev_valid=0, drop_cnt=0, ring empty, group_active=0.
- Edge detect: vin_d registers img_din_valid. start = img_din_valid & ~vin_d. Valid held high from reset out is not a start.
- Tracker states:
  - IDLE: no group active. On start: view=0, counts cleared, go to COUNT.
  - COUNT: on start with view<NUM_VIEWS-1, view <= view+1.
  - COUNT: on start with view==NUM_VIEWS-1, commit the group, clear counts, view <= 0, stay in COUNT.
- hit = feat_flag & feat_valid. Valid only in COUNT; ignored in IDLE.
- wr_en = hit & in COUNT & count[view] not saturated. This is combinational, same cycle as the descriptor. wr_addr = count[view]; wr_view = view.
- On a clock edge with wr_en, count[view] increments.
- A hit while count[view]==2^ADDR_W-1 sets ovf[view]; no write, no increment.
- Hit in a start cycle belongs to the outgoing view. It is included in that view's count or, at a group boundary, in the committed value.
- Commit: ring slot wr_ptr <= {counts incl. same-cycle hit, ovf}. commit pulses in the same cycle. Ring update is visible on rd_* the next cycle.
- Ring full at commit (occupancy==RING_DEPTH): group discarded, drop_cnt++ (saturating), commit still pulses, ring unchanged.
- rd_valid = occupancy!=0. rd_counts/rd_ovf show slot rd_ptr, registered.
- rd_release with rd_valid:
  - rd_prev_counts <= rd_counts, rd_prev_valid <= 1.
  - rd_ptr++ (wraps at RING_DEPTH), occupancy--.
  - rd_release with rd_valid=0 is ignored.
- Commit and release in the same cycle: both take effect, occupancy unchanged. A commit into a full ring with a simultaneous release is accepted, not dropped.
- Pointers wrap modulo RING_DEPTH; RING_DEPTH need not be a power of two.
- NUM_VIEWS=1: every start after the first commits.
- Reset mid-group discards partial counts and ring contents; the next start begins view 0.

Test Plan:
- Counting: NUM_VIEWS=2. Bursts L (5 hits), R (3 hits), then start of next L → commit pulse. Next cycle rd_valid=1, rd_counts view0=5, view1=3. wr_addr during L hits = 0..4.
- Boundary hit: hit coincident with the 3rd start, R has 2 prior hits → committed view1=3. Counts restart at 0 for the new L.
- Saturation: ADDR_W=3, 9 hits in view0 → wr_en for first 7 only; committed view0=7, rd_ovf[0]=1.
- Ring full: RING_DEPTH=2, 3 groups committed with no release → rd_counts = group1, drop_cnt=1. Release → rd_counts = group2, rd_prev_counts = group1, rd_prev_valid=1.
- Simultaneous: full ring, commit and release in the same cycle → drop_cnt unchanged, occupancy stays 2, new group appears after the remaining one.
- Reset mid-view: rst for 1 cycle after 4 hits in R → all outputs return to reset values. Next start counts from view0=0. Release while empty → no change.
